// File: rtl/tangcart_slot_io_bridge.sv
// Bridges asynchronous Z80 I/O cycles on the cartridge slot to a simple
// valid/ready request bus, stretching the Z80 with WAIT until the bus answers.
module tangcart_slot_io_bridge #(
    parameter logic [7:0] IO_BASE        = 8'h88,
    parameter int         PORT_COUNT     = 4,
    parameter int         SYNC_STAGES    = 2,
    parameter int         TIMEOUT_CYCLES = 1023,
    localparam int        ADDR_BITS      = $clog2(PORT_COUNT),
    localparam int        AW             = (ADDR_BITS < 1) ? 1 : ADDR_BITS
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [7:0]    slot_a,
    input  logic          slot_iorq_n,
    input  logic          slot_rd_n,
    input  logic          slot_wr_n,
    input  logic [7:0]    slot_d_in,
    output logic [7:0]    slot_d_out,
    output logic          slot_data_dir,
    output logic          slot_wait,
    output logic [AW-1:0] bus_address,
    output logic          bus_valid,
    output logic          bus_write,
    output logic [7:0]    bus_wdata,
    input  logic          bus_ready,
    input  logic [7:0]    bus_rdata,
    input  logic          bus_rdata_en,
    output logic [7:0]    timeout_count
);

    localparam logic [7:0]  PORT_MASK    = 8'(PORT_COUNT - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RDATA,
        S_HOLD,
        S_SKIP
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] iorq_pipe, rd_pipe, wr_pipe;
    logic                   iorq_s, rd_s, wr_s;

    logic [15:0]   cycle_cnt, cnt_next;
    logic          valid_next, write_next, dir_next, wait_next;
    logic [AW-1:0] addr_next;
    logic [7:0]    wdata_next, dout_next, tcount_next;

    logic          window_hit;
    logic [AW-1:0] port_index;

    assign window_hit = (slot_a & ~PORT_MASK) == (IO_BASE & ~PORT_MASK);
    assign port_index = AW'(slot_a & PORT_MASK);

    assign iorq_s = iorq_pipe[SYNC_STAGES-1];
    assign rd_s   = rd_pipe[SYNC_STAGES-1];
    assign wr_s   = wr_pipe[SYNC_STAGES-1];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            iorq_pipe <= '1;
            rd_pipe   <= '1;
            wr_pipe   <= '1;
        end else begin
            iorq_pipe <= {iorq_pipe[SYNC_STAGES-2:0], slot_iorq_n};
            rd_pipe   <= {rd_pipe[SYNC_STAGES-2:0], slot_rd_n};
            wr_pipe   <= {wr_pipe[SYNC_STAGES-2:0], slot_wr_n};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            bus_valid     <= 1'b0;
            bus_write     <= 1'b0;
            bus_address   <= '0;
            bus_wdata     <= 8'h00;
            slot_d_out    <= 8'hFF;
            slot_data_dir <= 1'b0;
            slot_wait     <= 1'b0;
            timeout_count <= 8'h00;
            cycle_cnt     <= 16'h0000;
        end else begin
            state         <= state_next;
            bus_valid     <= valid_next;
            bus_write     <= write_next;
            bus_address   <= addr_next;
            bus_wdata     <= wdata_next;
            slot_d_out    <= dout_next;
            slot_data_dir <= dir_next;
            slot_wait     <= wait_next;
            timeout_count <= tcount_next;
            cycle_cnt     <= cnt_next;
        end
    end

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        state_next  = state;
        valid_next  = bus_valid;
        write_next  = bus_write;
        addr_next   = bus_address;
        wdata_next  = bus_wdata;
        dout_next   = slot_d_out;
        dir_next    = slot_data_dir;
        wait_next   = slot_wait;
        tcount_next = timeout_count;
        cnt_next    = cycle_cnt;

        if (rd_s) begin
            dir_next = 1'b0;
        end

        unique case (state)
            // IDLE is only re-entered with iorq_n high, so the first low level seen here is the falling edge.
            S_IDLE: begin
                if (!iorq_s) begin
                    if (!rd_s && !wr_s) begin
                        state_next = S_SKIP;
                    end else if (rd_s != wr_s) begin
                        if (window_hit) begin
                            state_next = S_REQ;
                            valid_next = 1'b1;
                            wait_next  = 1'b1;
                            write_next = !wr_s;
                            addr_next  = port_index;
                            wdata_next = slot_d_in;
                            dir_next   = !rd_s;
                            cnt_next   = 16'h0000;
                        end else begin
                            state_next = S_SKIP;
                        end
                    end
                end
            end

            S_REQ, S_RDATA: begin
                if (state == S_REQ && bus_ready) begin
                    valid_next = 1'b0;
                    cnt_next   = cycle_cnt + 16'd1;
                    if (bus_write) begin
                        state_next = S_HOLD;
                        wait_next  = 1'b0;
                    end else begin
                        state_next = S_RDATA;
                    end
                end else if (state == S_RDATA && bus_rdata_en) begin
                    dout_next  = bus_rdata;
                    wait_next  = 1'b0;
                    state_next = S_HOLD;
                end else if (cycle_cnt >= TIMEOUT_LAST) begin
                    // Abort: release the Z80 and return all-ones on reads.
                    valid_next = 1'b0;
                    wait_next  = 1'b0;
                    state_next = S_HOLD;
                    if (!bus_write) begin
                        dout_next = 8'hFF;
                    end
                    if (timeout_count != 8'hFF) begin
                        tcount_next = timeout_count + 8'd1;
                    end
                end else begin
                    cnt_next = cycle_cnt + 16'd1;
                end
            end

            S_HOLD, S_SKIP: begin
                if (iorq_s) begin
                    state_next = S_IDLE;
                end
            end

            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_tangcart_slot_io_bridge.sv
// Scoreboard bench: three bridge instances (default, short timeout, 16-port window)
// share one slot bus; only the selected instance sees IORQ.
module tb_tangcart_slot_io_bridge;

    localparam int NINST        = 3;
    localparam int BURST_WRITES = 2048;

    typedef struct {
        int         inst;
        logic [3:0] addr;
        logic       write;
        logic [7:0] wdata;
    } bus_req_t;

    bus_req_t sb[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic [7:0] slot_a, slot_d_in;
    logic       slot_iorq_n, slot_rd_n, slot_wr_n;
    int         sel;

    logic [NINST-1:0] iorq_gate, data_dir, wait_o, bus_valid, bus_write;
    logic [NINST-1:0] bus_ready, bus_rdata_en;
    logic [7:0]       d_out [NINST];
    logic [7:0]       bus_wdata [NINST];
    logic [7:0]       timeout_count [NINST];
    logic [1:0]       addr_a, addr_t;
    logic [3:0]       addr_w;

    logic       ready_drv, en_drv;
    logic [7:0] rdata_drv;
    int         ready_delay, data_delay;
    logic [7:0] rsp_data;

    int tests = 0;
    int fails = 0;

    int pulses [NINST], valid_cyc [NINST], wait_cyc [NINST], dir_cyc [NINST];
    int p0 [NINST], v0 [NINST], w0 [NINST], d0 [NINST];
    logic [NINST-1:0] valid_prev;

    for (genvar k = 0; k < NINST; k++) begin : g_gate
        assign iorq_gate[k]    = (sel == k) ? slot_iorq_n : 1'b1;
        assign bus_ready[k]    = ready_drv && (sel == k);
        assign bus_rdata_en[k] = en_drv && (sel == k);
    end

    tangcart_slot_io_bridge dut_a (
        .clk(clk), .reset_n(reset_n), .slot_a(slot_a),
        .slot_iorq_n(iorq_gate[0]), .slot_rd_n(slot_rd_n), .slot_wr_n(slot_wr_n),
        .slot_d_in(slot_d_in), .slot_d_out(d_out[0]), .slot_data_dir(data_dir[0]),
        .slot_wait(wait_o[0]), .bus_address(addr_a), .bus_valid(bus_valid[0]),
        .bus_write(bus_write[0]), .bus_wdata(bus_wdata[0]), .bus_ready(bus_ready[0]),
        .bus_rdata(rdata_drv), .bus_rdata_en(bus_rdata_en[0]), .timeout_count(timeout_count[0])
    );

    tangcart_slot_io_bridge #(.TIMEOUT_CYCLES(16)) dut_t (
        .clk(clk), .reset_n(reset_n), .slot_a(slot_a),
        .slot_iorq_n(iorq_gate[1]), .slot_rd_n(slot_rd_n), .slot_wr_n(slot_wr_n),
        .slot_d_in(slot_d_in), .slot_d_out(d_out[1]), .slot_data_dir(data_dir[1]),
        .slot_wait(wait_o[1]), .bus_address(addr_t), .bus_valid(bus_valid[1]),
        .bus_write(bus_write[1]), .bus_wdata(bus_wdata[1]), .bus_ready(bus_ready[1]),
        .bus_rdata(rdata_drv), .bus_rdata_en(bus_rdata_en[1]), .timeout_count(timeout_count[1])
    );

    tangcart_slot_io_bridge #(.PORT_COUNT(16), .IO_BASE(8'h40)) dut_w (
        .clk(clk), .reset_n(reset_n), .slot_a(slot_a),
        .slot_iorq_n(iorq_gate[2]), .slot_rd_n(slot_rd_n), .slot_wr_n(slot_wr_n),
        .slot_d_in(slot_d_in), .slot_d_out(d_out[2]), .slot_data_dir(data_dir[2]),
        .slot_wait(wait_o[2]), .bus_address(addr_w), .bus_valid(bus_valid[2]),
        .bus_write(bus_write[2]), .bus_wdata(bus_wdata[2]), .bus_ready(bus_ready[2]),
        .bus_rdata(rdata_drv), .bus_rdata_en(bus_rdata_en[2]), .timeout_count(timeout_count[2])
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic expect_req(input int k, input logic [3:0] a, input logic w, input logic [7:0] d);
        sb.push_back('{inst: k, addr: a, write: w, wdata: d});
    endtask

    task automatic on_handshake(input int k);
        bus_req_t   e;
        logic [3:0] act_addr;
        act_addr = (k == 0) ? {2'b00, addr_a} : (k == 1) ? {2'b00, addr_t} : addr_w;
        check("sb_pending", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("req_inst", k, e.inst);
            check("req_addr", act_addr, e.addr);
            check("req_write", bus_write[k], e.write);
            if (e.write) check("req_wdata", bus_wdata[k], e.wdata);
        end
    endtask

    // Monitor: samples 1 ns after each falling edge, pops the scoreboard on every handshake.
    initial begin
        valid_prev = '0;
        for (int k = 0; k < NINST; k++) begin
            pulses[k] = 0; valid_cyc[k] = 0; wait_cyc[k] = 0; dir_cyc[k] = 0;
        end
        forever begin
            @(negedge clk);
            #1;
            for (int k = 0; k < NINST; k++) begin
                if (bus_valid[k]) valid_cyc[k]++;
                if (bus_valid[k] && !valid_prev[k]) pulses[k]++;
                if (wait_o[k]) wait_cyc[k]++;
                if (data_dir[k]) dir_cyc[k]++;
                if (bus_valid[k] && bus_ready[k]) on_handshake(k);
            end
            valid_prev = bus_valid;
        end
    end

    // Bus responder for the selected instance: ready after ready_delay, read data data_delay later.
    initial begin
        logic is_rd;
        ready_drv = 1'b0;
        en_drv    = 1'b0;
        rdata_drv = 8'h00;
        forever begin
            @(negedge clk);
            if (bus_valid[sel] && ready_delay >= 0) begin
                is_rd = !bus_write[sel];
                repeat (ready_delay) @(negedge clk);
                ready_drv = 1'b1;
                @(negedge clk);
                ready_drv = 1'b0;
                if (is_rd) begin
                    repeat (data_delay - 1) @(negedge clk);
                    rdata_drv = rsp_data;
                    en_drv    = 1'b1;
                    @(negedge clk);
                    en_drv    = 1'b0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic snap();
        for (int k = 0; k < NINST; k++) begin
            p0[k] = pulses[k]; v0[k] = valid_cyc[k]; w0[k] = wait_cyc[k]; d0[k] = dir_cyc[k];
        end
    endtask

    task automatic slot_io(input int k, input logic [7:0] a, input logic rd, input logic wr,
                           input logic [7:0] d, input int low_cycles, input int high_cycles);
        @(negedge clk);
        sel         = k;
        slot_a      = a;
        slot_d_in   = d;
        slot_iorq_n = 1'b0;
        slot_rd_n   = !rd;
        slot_wr_n   = !wr;
        repeat (low_cycles) @(negedge clk);
        slot_iorq_n = 1'b1;
        slot_rd_n   = 1'b1;
        slot_wr_n   = 1'b1;
        repeat (high_cycles) @(negedge clk);
    endtask

    initial begin
        bit seen;
        int dd;
        sel = 0; slot_a = 8'h00; slot_d_in = 8'h00;
        slot_iorq_n = 1'b1; slot_rd_n = 1'b1; slot_wr_n = 1'b1;
        ready_delay = 0; data_delay = 1; rsp_data = 8'h00;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);

        for (int k = 0; k < NINST; k++) begin
            check("rst_dout", d_out[k], 8'hFF);
            check("rst_valid", bus_valid[k], 0);
            check("rst_wait", wait_o[k], 0);
            check("rst_dir", data_dir[k], 0);
            check("rst_tcount", timeout_count[k], 0);
            check("rst_wdata", bus_wdata[k], 0);
        end
        check("rst_addr_w", addr_w, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write 0x43 to port 0x89, ready immediate.
        snap(); ready_delay = 0;
        expect_req(0, 4'd1, 1'b1, 8'h43);
        slot_io(0, 8'h89, 1'b0, 1'b1, 8'h43, 8, 6);
        check("wr_pulses", pulses[0] - p0[0], 1);
        check("wr_wait_cycles", wait_cyc[0] - w0[0], 1);
        check("wr_dir_cycles", dir_cyc[0] - d0[0], 0);

        // Read port 0x88: ready after 20 cycles, data 3 cycles later.
        snap(); ready_delay = 20; data_delay = 3; rsp_data = 8'h5A;
        expect_req(0, 4'd0, 1'b0, 8'h00);
        slot_io(0, 8'h88, 1'b1, 1'b0, 8'h00, 40, 6);
        check("rd_valid_cycles", valid_cyc[0] - v0[0], 21);
        check("rd_wait_cycles", wait_cyc[0] - w0[0], 24);
        dd = dir_cyc[0] - d0[0];
        check("rd_dir_cycles_39_41", 32'(dd >= 39 && dd <= 41), 1);
        check("rd_dout", d_out[0], 8'h5A);
        check("rd_dir_released", data_dir[0], 0);

        // rd_n and wr_n both low, then unmatched writes: no bus activity.
        snap(); ready_delay = 0;
        slot_io(0, 8'h88, 1'b1, 1'b1, 8'h11, 8, 6);
        slot_io(0, 8'h98, 1'b0, 1'b1, 8'h22, 8, 6);
        slot_io(0, 8'h8C, 1'b0, 1'b1, 8'h33, 8, 6);
        check("skip_pulses", pulses[0] - p0[0], 0);
        check("skip_wait_cycles", wait_cyc[0] - w0[0], 0);
        check("skip_dir_cycles", dir_cyc[0] - d0[0], 0);

        // iorq_n released while the read is still pending: it must still complete.
        snap(); ready_delay = 10; data_delay = 1; rsp_data = 8'h77;
        expect_req(0, 4'd1, 1'b0, 8'h00);
        slot_io(0, 8'h89, 1'b1, 1'b0, 8'h00, 4, 30);
        check("early_iorq_pulses", pulses[0] - p0[0], 1);
        check("early_iorq_dout", d_out[0], 8'h77);
        check("early_iorq_wait", wait_o[0], 0);

        // Short-timeout instance: prime slot_d_out, then let a read time out.
        ready_delay = 2; data_delay = 1; rsp_data = 8'h33;
        expect_req(1, 4'd1, 1'b0, 8'h00);
        slot_io(1, 8'h89, 1'b1, 1'b0, 8'h00, 12, 6);
        check("to_prime_dout", d_out[1], 8'h33);
        check("to_prime_tcount", timeout_count[1], 0);
        snap(); ready_delay = -1;
        slot_io(1, 8'h8A, 1'b1, 1'b0, 8'h00, 30, 6);
        check("to_valid_cycles", valid_cyc[1] - v0[1], 16);
        check("to_wait_cycles", wait_cyc[1] - w0[1], 16);
        check("to_pulses", pulses[1] - p0[1], 1);
        check("to_dout", d_out[1], 8'hFF);
        check("to_tcount", timeout_count[1], 1);
        for (int i = 0; i < 255; i++) slot_io(1, 8'h8B, 1'b1, 1'b0, 8'h00, 20, 4);
        check("to_tcount_saturated", timeout_count[1], 8'hFF);

        // Reset while a write sits in REQ.
        snap(); ready_delay = -1;
        @(negedge clk);
        sel = 0; slot_a = 8'h8A; slot_d_in = 8'hAA;
        slot_iorq_n = 1'b0; slot_wr_n = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (bus_valid[0]) seen = 1'b1;
        end
        check("rstreq_seen", seen, 1);
        check("rstreq_wait_before", wait_o[0], 1);
        #3 reset_n = 1'b0;
        #1;
        check("rstreq_valid", bus_valid[0], 0);
        check("rstreq_write", bus_write[0], 0);
        check("rstreq_addr", addr_a, 0);
        check("rstreq_wdata", bus_wdata[0], 0);
        check("rstreq_dout", d_out[0], 8'hFF);
        check("rstreq_dir", data_dir[0], 0);
        check("rstreq_wait", wait_o[0], 0);
        check("rstreq_tcount_t", timeout_count[1], 0);
        @(negedge clk);
        slot_iorq_n = 1'b1; slot_wr_n = 1'b1;
        repeat (3) @(negedge clk);
        snap();
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("rstreq_no_pulse", pulses[0] - p0[0], 0);
        ready_delay = 0;
        expect_req(0, 4'd3, 1'b1, 8'hC3);
        slot_io(0, 8'h8B, 1'b0, 1'b1, 8'hC3, 8, 6);
        check("post_rst_pulses", pulses[0] - p0[0], 1);
        check("post_rst_wait_cycles", wait_cyc[0] - w0[0], 1);

        // 16-port window at 0x40.
        snap(); ready_delay = 0;
        expect_req(2, 4'd15, 1'b1, 8'h7E);
        slot_io(2, 8'h4F, 1'b0, 1'b1, 8'h7E, 8, 6);
        slot_io(2, 8'h50, 1'b0, 1'b1, 8'h01, 8, 6);
        check("w16_pulses", pulses[2] - p0[2], 1);
        snap();
        for (int i = 0; i < BURST_WRITES; i++) begin
            logic [7:0] d;
            d = i[7:0] ^ 8'h5C;
            expect_req(2, i[3:0], 1'b1, d);
            slot_io(2, {4'h4, i[3:0]}, 1'b0, 1'b1, d, 4, 4);
        end
        check("burst_pulses", pulses[2] - p0[2], BURST_WRITES);
        check("burst_valid_cycles", valid_cyc[2] - v0[2], BURST_WRITES);

        repeat (5) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
